// File: rtl/cheri_tsmap_arbiter_pkg.sv
// Shared types and widths for the TS map arbiter.
// Also provides the bit-SET/CLR helper used by the read-modify-write path.
package cheri_tsmap_arbiter_pkg;

  localparam int TSMAP_ADDR_W = 16;
  localparam int TSMAP_DATA_W = 32;

  typedef enum logic [1:0] {
    TSMAP_READ  = 2'd0,
    TSMAP_WRITE = 2'd1,
    TSMAP_SET   = 2'd2,
    TSMAP_CLR   = 2'd3
  } tsmap_op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_PEND = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_PEND = 3'd3,
    ST_RESP    = 3'd4
  } arb_state_e;

  function automatic logic [TSMAP_DATA_W-1:0] tsmap_rmw(
    input tsmap_op_e               op,
    input logic [TSMAP_DATA_W-1:0] old_val,
    input logic [TSMAP_DATA_W-1:0] mask
  );
    case (op)
      TSMAP_SET: return old_val | mask;
      TSMAP_CLR: return old_val & ~mask;
      default:   return old_val;
    endcase
  endfunction

endpackage

// File: rtl/cheri_tsmap_arbiter_if.sv
// Host/revoker maintenance port of the TS map arbiter.
// The master is the requester and the slave is the arbiter.
interface cheri_tsmap_arbiter_if;
  import cheri_tsmap_arbiter_pkg::*;

  logic                    host_req;
  logic                    host_gnt;
  tsmap_op_e               host_op;
  logic [TSMAP_ADDR_W-1:0] host_addr;
  logic [TSMAP_DATA_W-1:0] host_wdata;
  logic                    host_rvalid;
  logic [TSMAP_DATA_W-1:0] host_rdata;
  logic                    host_err;

  modport master (
    output host_req, host_op, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata, host_err
  );

  modport slave (
    input  host_req, host_op, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata, host_err
  );

endinterface

// File: rtl/cheri_tsmap_arbiter.sv
// Single-port TS map SRAM arbiter: the core read port always wins, and host
// READ/WRITE/SET/CLR operations are slotted into core-idle cycles by an FSM.
module cheri_tsmap_arbiter
  import cheri_tsmap_arbiter_pkg::*;
#(
  parameter int TSMapSize = 1024,
  parameter int StarveMax = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    core_tsmap_cs_i,
  input  logic [TSMAP_ADDR_W-1:0] core_tsmap_addr_i,
  output logic [TSMAP_DATA_W-1:0] core_tsmap_rdata_o,
  cheri_tsmap_arbiter_if.slave    host,
  output logic                    host_starve_o,
  output logic                    mem_cs_o,
  output logic                    mem_we_o,
  output logic [TSMAP_ADDR_W-1:0] mem_addr_o,
  output logic [TSMAP_DATA_W-1:0] mem_wdata_o,
  input  logic [TSMAP_DATA_W-1:0] mem_rdata_i,
  output logic                    busy_o
);

  localparam int CntW = $clog2(StarveMax + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(StarveMax);

  arb_state_e              r_state;
  arb_state_e              w_state_nxt;
  tsmap_op_e               r_op;
  logic [TSMAP_ADDR_W-1:0] r_addr;
  logic [TSMAP_DATA_W-1:0] r_wdata;
  logic [TSMAP_DATA_W-1:0] r_old;
  logic [TSMAP_DATA_W-1:0] r_new;
  logic                    r_err;
  logic [CntW-1:0]         r_cnt;
  logic                    r_starve;

  logic w_gnt;
  logic w_in_range;
  logic w_stall;
  logic w_host_rd;
  logic w_host_wr;

  // Host accesses are masked during reset so a pending op can never reach the SRAM.
  assign w_gnt      = rst_ni && (r_state == ST_IDLE) && host.host_req;
  assign w_in_range = (32'(host.host_addr) < 32'(TSMapSize));
  assign w_stall    = core_tsmap_cs_i &&
                      ((r_state == ST_RD_PEND) || (r_state == ST_WR_PEND));
  assign w_host_rd  = rst_ni && !core_tsmap_cs_i && (r_state == ST_RD_PEND);
  assign w_host_wr  = rst_ni && !core_tsmap_cs_i && (r_state == ST_WR_PEND);

  assign core_tsmap_rdata_o = mem_rdata_i;
  assign host.host_gnt      = w_gnt;
  assign host.host_rvalid   = (r_state == ST_RESP);
  assign host.host_rdata    = r_old;
  assign host.host_err      = r_err;
  assign host_starve_o      = r_starve;
  assign busy_o             = (r_state != ST_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt) begin
          if (!w_in_range)                      w_state_nxt = ST_RESP;
          else if (host.host_op == TSMAP_WRITE) w_state_nxt = ST_WR_PEND;
          else                                  w_state_nxt = ST_RD_PEND;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD_PEND: begin
        if (w_host_rd) w_state_nxt = ST_RD_DATA;
        else           w_state_nxt = ST_RD_PEND;
      end
      ST_RD_DATA: begin
        if (r_op == TSMAP_READ) w_state_nxt = ST_RESP;
        else                    w_state_nxt = ST_WR_PEND;
      end
      ST_WR_PEND: begin
        if (w_host_wr) w_state_nxt = ST_RESP;
        else           w_state_nxt = ST_WR_PEND;
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_cs_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (core_tsmap_cs_i) begin
      mem_cs_o   = 1'b1;
      mem_addr_o = core_tsmap_addr_i;
    end else if (w_host_rd) begin
      mem_cs_o   = 1'b1;
      mem_addr_o = r_addr;
    end else if (w_host_wr) begin
      mem_cs_o    = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = r_addr;
      mem_wdata_o = (r_op == TSMAP_WRITE) ? r_wdata : r_new;
    end else begin
      mem_cs_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state  <= ST_IDLE;
      r_op     <= TSMAP_READ;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_old    <= '0;
      r_new    <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      r_starve <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_gnt) begin
        r_op    <= host.host_op;
        r_addr  <= host.host_addr;
        r_wdata <= host.host_wdata;
        r_old   <= '0;
        r_err   <= !w_in_range;
      end
      // RD_DATA issues no access, so mem_rdata_i still holds the host's read.
      if (r_state == ST_RD_DATA) begin
        r_old <= mem_rdata_i;
        r_new <= tsmap_rmw(r_op, mem_rdata_i, r_wdata);
      end
      if (w_host_rd || w_host_wr) begin
        r_cnt <= '0;
      end else if (w_stall && (r_cnt != CntMax)) begin
        r_cnt <= r_cnt + CntW'(1);
      end
      if (w_stall && (r_cnt == CntMax - CntW'(1))) begin
        r_starve <= 1'b1;
      end
    end
  end

endmodule

// File: doc/cheri_tsmap_arbiter.md
Name: cheri_tsmap_arbiter

Overview:
Shares the single-port TS map SRAM between two requesters: the core's fixed-latency read port (tsmap_cs/addr/rdata) and a host/revoker maintenance port that does READ, WRITE, bit-SET and bit-CLR. SET and CLR are read-modify-write operations.
The core port has absolute priority because it has no grant signal. Host operations are sequenced around core accesses by an FSM.
The block sits between the ibexc_top TS map interface and the SRAM macro.

Parameters:
TSMapSize, 1024, number of 32-bit words in the map; host addresses >= TSMapSize return an error.
StarveMax, 64, consecutive host-stall cycles before host_starve_o is set.

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
core_tsmap_cs_i  in  1  core read strobe
core_tsmap_addr_i  in  16  core word address
core_tsmap_rdata_o  out  32  core read data, valid the cycle after cs
host_req_i  in  1  host request
host_gnt_o  out  1  host request accepted this cycle
host_op_i  in  2  tsmap_op_e: READ=0, WRITE=1, SET=2, CLR=3
host_addr_i  in  16  host word address
host_wdata_i  in  32  write data (WRITE) or bit mask (SET/CLR)
host_rvalid_o  out  1  one-cycle response pulse
host_rdata_o  out  32  pre-op word value; 0 for WRITE
host_err_o  out  1  address out of range; qualified by host_rvalid_o
host_starve_o  out  1  sticky starvation flag
mem_cs_o  out  1  SRAM chip select
mem_we_o  out  1  SRAM write enable
mem_addr_o  out  16  SRAM word address
mem_wdata_o  out  32  SRAM write data
mem_rdata_i  in  32  SRAM read data, 1-cycle latency, held until the next read
busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset (rst_ni low at a clock edge):
  - FSM goes to IDLE; op/addr/data/old registers and the starve counter clear to 0.
  - host_rvalid_o, host_err_o, host_starve_o, busy_o and host_gnt_o are 0.
  - While rst_ni is low, host_gnt_o is forced to 0 and mem_* is driven by the core path only.
  - A host operation interrupted by reset is abandoned. No pending write is issued afterwards and no response is given.
- Core path:
  - When core_tsmap_cs_i=1: mem_cs_o=1, mem_we_o=0, mem_addr_o=core_tsmap_addr_i, every cycle, regardless of FSM state.
  - core_tsmap_rdata_o = mem_rdata_i as a combinational pass-through.
  - The core is never stalled.
- Host FSM states: IDLE, RD_PEND, RD_DATA, WR_PEND, RESP.
- IDLE:
  - host_gnt_o = host_req_i.
  - On grant, latch op, addr and wdata.
  - If addr >= TSMapSize, go to RESP with err=1 and no memory access.
  - Otherwise WRITE goes to WR_PEND; READ, SET and CLR go to RD_PEND.
  - Earliest grant is one cycle after the preceding rvalid.
- RD_PEND:
  - If core_tsmap_cs_i=1, stall.
  - Else drive mem_cs_o=1, we=0, addr=latched addr, and go to RD_DATA.
- RD_DATA:
  - Capture mem_rdata_i into old_q.
  - new_q = old|mask for SET, old&~mask for CLR.
  - READ goes to RESP; SET and CLR go to WR_PEND.
  - No memory access in this state, so the core does not overwrite the captured value.
- WR_PEND:
  - If core_tsmap_cs_i=1, stall.
  - Else drive mem_cs_o=1, we=1, addr=latched addr, wdata = new_q (SET/CLR) or latched wdata (WRITE), and go to RESP.
- RESP:
  - host_rvalid_o=1 for exactly one cycle.
  - host_rdata_o = old_q (0 for WRITE and for errors); host_err_o as latched.
  - Next state is IDLE.
- Latency with no core traffic:
  - READ: gnt to rvalid is 3 cycles.
  - SET/CLR: 4 cycles.
  - WRITE: 2 cycles.
  - Error: 1 cycle.
  - Each core-occupied cycle in a PEND state adds 1 cycle.
- Consistency:
  - The host is the only writer and has one operation outstanding, so an RMW is atomic with respect to the core.
  - A core read of the address during an RMW returns the pre-write value until the write cycle has completed.
  - A core read on the cycle after the write returns the new value.
- Starvation counter:
  - Width clog2(StarveMax+1); increments on each stalled PEND cycle and saturates.
  - Resets to 0 when a host memory access issues.
  - host_starve_o sets when the count reaches StarveMax and stays set until reset.
- Simultaneous core cs and host grant in IDLE: both proceed; only the core touches memory that cycle.
- busy_o = (state != IDLE).

Decomposition:
- Add tsmap_op_e (2-bit) to cheri_pkg, plus localparams TSMAP_ADDR_W=16 and TSMAP_DATA_W=32.
- No sub-module: the FSM, RMW datapath and saturating counter fit in one module.

Test Plan:
- Host READ addr 0x010 holding 0xDEAD_BEEF, core idle -> mem read in the cycle after gnt; rvalid 3 cycles after gnt with rdata=0xDEAD_BEEF, err=0.
- Host SET addr 5 (word 0x0000_00F0), mask 0x0000_000F -> mem write 0x0000_00FF; rvalid 4 cycles after gnt, rdata=0x0000_00F0. Repeat with CLR mask 0x0000_0030 -> writes 0x0000_00CF.
- Core cs held high for 10 cycles during host WRITE addr 3 data 0x1234_5678 -> no host mem access during the burst; write issues in the first core-idle cycle; core_tsmap_rdata_o tracks each core read.
- Host READ addr 1024 (TSMapSize) -> no mem_cs_o; rvalid 1 cycle after gnt with err=1, rdata=0.
- Core cs high for 70 cycles with a host READ pending -> host_starve_o rises after 64 stalled cycles and stays set after the READ completes.
- rst_ni low for one cycle while in WR_PEND of a SET -> no write issued; FSM in IDLE; no rvalid; word unchanged on a subsequent READ.
